// File: rtl/muldiv_seq_if.sv
// Handshake bundle between the exe stage and the iterative M-extension engine.
interface muldiv_seq_if #(
    parameter int XLEN = 64
);
    logic            start;
    logic            flush;
    logic [2:0]      func3;
    logic            is_word;
    logic            rs1_sign;
    logic            rs2_sign;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            busy;
    logic            stall_req;
    logic            result_valid;
    logic [XLEN-1:0] result;

    modport master (
        output start, flush, func3, is_word, rs1_sign, rs2_sign, src1, src2,
        input  busy, stall_req, result_valid, result
    );

    modport slave (
        input  start, flush, func3, is_word, rs1_sign, rs2_sign, src1, src2,
        output busy, stall_req, result_valid, result
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV64M engine: radix-2 shift-add multiply and restoring divide.
// Optional macro MULDIV_EARLY_OUT_EN finishes trivial operands after one CALC cycle.
module muldiv_seq #(
    parameter int XLEN = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    muldiv_seq_if.slave bus
);
    localparam int HALF = XLEN / 2;
    localparam int CW   = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_next;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opa, opb, result_q;
    logic              is_mul, sel_lo, sel_rem, word_q, neg_q, neg_r;
    logic              accept, last, early;

    logic [XLEN-1:0]   ext1, ext2, mag1, mag2;
    logic              neg1, neg2;
    logic [2*XLEN-1:0] acc_step, acc_fin, prod;
    logic [XLEN-1:0]   opb_step, quo, rem, res_full, res_fix;
    logic [XLEN:0]     trial;

    assign accept = (state == IDLE) && bus.start && !bus.flush;
    assign last   = (count == CW'(1)) || early;

    // Sign/zero-extend the selected operand width, then reduce to magnitude.
    always_comb begin
        neg1 = bus.rs1_sign & (bus.is_word ? bus.src1[HALF-1] : bus.src1[XLEN-1]);
        neg2 = bus.rs2_sign & (bus.is_word ? bus.src2[HALF-1] : bus.src2[XLEN-1]);
        ext1 = bus.is_word ? {{HALF{neg1}}, bus.src1[HALF-1:0]} : bus.src1;
        ext2 = bus.is_word ? {{HALF{neg2}}, bus.src2[HALF-1:0]} : bus.src2;
        mag1 = neg1 ? -ext1 : ext1;
        mag2 = neg2 ? -ext2 : ext2;
    end

    // Multiply consumes multiplier bits MSB-first; divide keeps {remainder, quotient} in acc.
    always_comb begin
        acc_step = acc;
        opb_step = opb;
        trial    = '0;
        if (is_mul) begin
            acc_step = {acc[2*XLEN-2:0], 1'b0} + (opb[XLEN-1] ? {{XLEN{1'b0}}, opa} : '0);
            opb_step = {opb[XLEN-2:0], 1'b0};
        end else begin
            trial = acc[2*XLEN-1:XLEN-1] - {1'b0, opa};
            if (trial[XLEN]) begin
                acc_step = {acc[2*XLEN-2:0], 1'b0};
            end else begin
                acc_step = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic            first;
    logic [XLEN-1:0] dvd_mag;

    always_comb begin
        dvd_mag = word_q ? {{HALF{1'b0}}, acc[XLEN-1:HALF]} : acc[XLEN-1:0];
        early   = 1'b0;
        acc_fin = acc_step;
        if (first && (state == CALC)) begin
            if (is_mul) begin
                if ((opa == '0) || (opb == '0)) begin
                    early   = 1'b1;
                    acc_fin = '0;
                end
            end else if (opa == '0) begin
                early   = 1'b1;
                acc_fin = {dvd_mag, {XLEN{1'b1}}};
            end else if (dvd_mag < opa) begin
                early   = 1'b1;
                acc_fin = {dvd_mag, {XLEN{1'b0}}};
            end
        end
    end
`else
    assign early   = 1'b0;
    assign acc_fin = acc_step;
`endif

    // Sign fixup and result selection; word results always re-extend bit 31.
    always_comb begin
        prod     = neg_q ? -acc_fin : acc_fin;
        quo      = neg_q ? -acc_fin[XLEN-1:0] : acc_fin[XLEN-1:0];
        rem      = neg_r ? -acc_fin[2*XLEN-1:XLEN] : acc_fin[2*XLEN-1:XLEN];
        if (is_mul) begin
            res_full = sel_lo ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end else begin
            res_full = sel_rem ? rem : quo;
        end
        res_fix = word_q ? {{HALF{res_full[HALF-1]}}, res_full[HALF-1:0]} : res_full;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // stall_req stays low in DONE so exe advances and captures the result.
    always_comb begin
        state_next       = state;
        bus.busy         = (state != IDLE);
        bus.stall_req    = 1'b0;
        bus.result_valid = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next    = CALC;
                    bus.stall_req = 1'b1;
                end
            end
            CALC: begin
                bus.stall_req = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.result_valid = !bus.flush;
                state_next       = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (bus.flush) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            acc      <= '0;
            opa      <= '0;
            opb      <= '0;
            result_q <= '0;
            is_mul   <= 1'b0;
            sel_lo   <= 1'b0;
            sel_rem  <= 1'b0;
            word_q   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
            first    <= 1'b0;
`endif
        end else if (accept) begin
            count   <= bus.is_word ? CW'(HALF) : CW'(XLEN);
            is_mul  <= ~bus.func3[2];
            sel_lo  <= (bus.func3[1:0] == 2'b00);
            sel_rem <= bus.func3[1];
            word_q  <= bus.is_word;
            opa     <= bus.func3[2] ? mag2 : mag1;
            opb     <= bus.is_word ? (mag2 << HALF) : mag2;
            acc     <= bus.func3[2] ? {{XLEN{1'b0}}, (bus.is_word ? (mag1 << HALF) : mag1)} : '0;
            // A zero divisor returns all ones with no sign fixup on the quotient.
            neg_q   <= (neg1 ^ neg2) & (~bus.func3[2] | (mag2 != '0));
            neg_r   <= bus.func3[2] & neg1;
`ifdef MULDIV_EARLY_OUT_EN
            first   <= 1'b1;
`endif
        end else if ((state == CALC) && !bus.flush) begin
            acc   <= acc_step;
            opb   <= opb_step;
            count <= last ? '0 : count - CW'(1);
            if (last) begin
                result_q <= res_fix;
            end
`ifdef MULDIV_EARLY_OUT_EN
            first <= 1'b0;
`endif
        end
    end

    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: random and directed M-ops against a plain-arithmetic model.
module tb_muldiv_seq;
    localparam int XLEN = 64;

    typedef struct {
        logic [63:0] value;
        int unsigned due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [63:0] last_result = '0;
    exp_t        sb[$];

    muldiv_seq_if #(.XLEN(XLEN)) bus ();

    muldiv_seq #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic sign1(input logic [2:0] f3);
        return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
    endfunction

    function automatic logic sign2(input logic [2:0] f3);
        return f3 inside {3'b000, 3'b001, 3'b100, 3'b110};
    endfunction

    function automatic logic [63:0] sext32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    // Architectural RV64M results, computed directly from the instruction semantics.
    function automatic logic [63:0] ref_result(input logic [2:0] f3, input logic w,
                                               input logic [63:0] a, input logic [63:0] b);
        logic [127:0] pa, pb, p;
        logic [31:0]  a32, b32, r32;
        logic [63:0]  r;
        a32 = a[31:0];
        b32 = b[31:0];
        r32 = '0;
        r   = '0;
        if (w) begin
            case (f3)
                3'b000: r32 = a32 * b32;
                3'b100: begin
                    if (b32 == 0) r32 = '1;
                    else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = a32;
                    else r32 = $signed(a32) / $signed(b32);
                end
                3'b101: r32 = (b32 == 0) ? 32'hFFFF_FFFF : a32 / b32;
                3'b110: begin
                    if (b32 == 0) r32 = a32;
                    else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = '0;
                    else r32 = $signed(a32) % $signed(b32);
                end
                3'b111: r32 = (b32 == 0) ? a32 : a32 % b32;
                default: r32 = '0;
            endcase
            r = sext32(r32);
        end else begin
            pa = {{64{a[63] & sign1(f3)}}, a};
            pb = {{64{b[63] & sign2(f3)}}, b};
            p  = pa * pb;
            case (f3)
                3'b000: r = p[63:0];
                3'b001, 3'b010, 3'b011: r = p[127:64];
                3'b100: begin
                    if (b == 0) r = '1;
                    else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
                    else r = $signed(a) / $signed(b);
                end
                3'b101: r = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
                3'b110: begin
                    if (b == 0) r = a;
                    else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
                    else r = $signed(a) % $signed(b);
                end
                default: r = (b == 0) ? a : a % b;
            endcase
        end
        return r;
    endfunction

    // Cycles from start to result_valid.
    function automatic int unsigned ref_latency(input logic [2:0] f3, input logic w,
                                                input logic [63:0] a, input logic [63:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        logic [63:0] va, vb;
        va = w ? (sign1(f3) ? sext32(a[31:0]) : {32'h0, a[31:0]}) : a;
        vb = w ? (sign2(f3) ? sext32(b[31:0]) : {32'h0, b[31:0]}) : b;
        if (sign1(f3) && va[63]) va = -va;
        if (sign2(f3) && vb[63]) vb = -vb;
        if (!f3[2]) begin
            if (va == 0 || vb == 0) return 2;
        end else if (vb == 0 || va < vb) begin
            return 2;
        end
`endif
        return w ? 33 : 65;
    endfunction

    function automatic logic [63:0] rand_operand();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = '1;
            2: v = 64'h8000_0000_0000_0000;
            3: v = 64'hFFFF_FFFF_8000_0000;
            4: v = 64'($urandom_range(0, 20));
            5: v = -64'($urandom_range(1, 20));
            6: v = {32'h0, $urandom};
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic drive_op(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b);
        bus.start    = 1'b1;
        bus.func3    = f3;
        bus.is_word  = w;
        bus.rs1_sign = sign1(f3);
        bus.rs2_sign = sign2(f3);
        bus.src1     = a;
        bus.src2     = b;
    endtask

    // Issue one op, push its expectation, and wait (bounded) for the engine to return to idle.
    task automatic apply_stimulus(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b);
        exp_t        e;
        int unsigned lat;
        int          stall_cnt;
        int          waited;
        lat = ref_latency(f3, w, a, b);
        @(negedge clk);
        e.value = ref_result(f3, w, a, b);
        e.due   = cyc + lat;
        sb.push_back(e);
        drive_op(f3, w, a, b);
        #1;
        stall_cnt = bus.stall_req ? 1 : 0;
        waited    = 0;
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            if (bus.stall_req) stall_cnt++;
            waited++;
        end while (bus.busy && waited < 300);
        if (bus.busy) begin
            checks++;
            failures++;
            $display("[TB] FAIL op_timeout: got busy=1 after %0d cycles, expected idle", waited);
        end
        check_output("stall_cycles", 64'(stall_cnt), 64'(lat));
        last_result = e.value;
    endtask

    task automatic flush_test();
        @(negedge clk);
        drive_op(3'b100, 1'b0, 64'd1000000, 64'd3);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        check_output("flush_busy", 64'(bus.busy), 64'd0);
        check_output("flush_stall", 64'(bus.stall_req), 64'd0);
        check_output("flush_valid", 64'(bus.result_valid), 64'd0);
        check_output("flush_result_held", bus.result, last_result);
    endtask

    task automatic reset_test();
        @(negedge clk);
        drive_op(3'b000, 1'b0, 64'd12345, 64'd678);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("rst_busy", 64'(bus.busy), 64'd0);
        check_output("rst_stall", 64'(bus.stall_req), 64'd0);
        check_output("rst_valid", 64'(bus.result_valid), 64'd0);
        check_output("rst_result", bus.result, 64'd0);
        sb.delete();
        last_result = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: pops one expectation per result_valid pulse.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n && bus.result_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_valid: got result %h, expected no result", bus.result);
                end else begin
                    e = sb.pop_front();
                    check_output("result", bus.result, e.value);
                    check_output("latency", 64'(cyc), 64'(e.due));
                end
            end
        end
    end

    initial begin
        logic [2:0]  f3;
        logic        w;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.flush    = 1'b0;
        bus.func3    = '0;
        bus.is_word  = 1'b0;
        bus.rs1_sign = 1'b0;
        bus.rs2_sign = 1'b0;
        bus.src1     = '0;
        bus.src2     = '0;
        repeat (3) @(negedge clk);
        check_output("reset_busy", 64'(bus.busy), 64'd0);
        check_output("reset_stall", 64'(bus.stall_req), 64'd0);
        check_output("reset_valid", 64'(bus.result_valid), 64'd0);
        check_output("reset_result", bus.result, 64'd0);
        rst_n = 1'b1;

        $display("[TB] directed ops");
        apply_stimulus(3'b000, 1'b0, 64'd3, 64'd5);
        apply_stimulus(3'b011, 1'b0, '1, '1);
        apply_stimulus(3'b001, 1'b0, '1, '1);
        apply_stimulus(3'b100, 1'b1, -64'd7, 64'd2);
        apply_stimulus(3'b110, 1'b1, -64'd7, 64'd2);
        apply_stimulus(3'b101, 1'b0, 64'd10, 64'd0);
        apply_stimulus(3'b111, 1'b0, 64'd10, 64'd0);
        apply_stimulus(3'b100, 1'b0, 64'h8000_0000_0000_0000, '1);
        apply_stimulus(3'b110, 1'b0, 64'h8000_0000_0000_0000, '1);
        apply_stimulus(3'b000, 1'b0, 64'd7, 64'd0);

        $display("[TB] flush and reset");
        flush_test();
        apply_stimulus(3'b100, 1'b0, 64'd1000000, 64'd3);
        reset_test();
        apply_stimulus(3'b010, 1'b0, -64'd9, 64'd4);

        $display("[TB] random ops");
        for (int i = 0; i < 60; i++) begin
            f3 = 3'($urandom_range(0, 7));
            w  = 1'($urandom_range(0, 1));
            if (f3 inside {3'b001, 3'b010, 3'b011}) w = 1'b0;
            apply_stimulus(f3, w, rand_operand(), rand_operand());
        end

        repeat (3) @(negedge clk);
        check_output("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
